// File: rtl/mm_sequencer.sv
// mm_sequencer: streams A/B operands into a thread grid, starts the dot products and reads back C.
// Define MM_SEQUENCER_TIMEOUT_EN to add a watchdog that abandons a job stuck in WAIT.
module mm_sequencer #(
  parameter int MAX_DIM        = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_valid,
  input  logic [3:0]  a1,
  input  logic [3:0]  a2,
  input  logic [3:0]  a3,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic [3:0]  row,
  output logic [3:0]  col,
  output logic        readA,
  output logic        readB,
  output logic [31:0] Din,
  output logic        start_mm,
  output logic        ack_ticks,
  input  logic        all_finished,
  output logic [3:0]  res_row,
  output logic [3:0]  res_col,
  input  logic [31:0] acc_in,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        busy,
  output logic        done,
  output logic        cfg_err
);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, START, WAIT, READOUT, ACK
  } state_t;

  localparam logic [4:0] MAX_DIM_W = 5'(MAX_DIM);

  state_t      state_reg, state_next;
  logic [3:0]  a1m_reg, a2m_reg, a3m_reg;
  logic [3:0]  ld_row_reg, ld_col_reg;
  logic [3:0]  row_reg, col_reg;
  logic [31:0] din_reg;
  logic        read_a_reg, read_b_reg;
  logic [3:0]  res_row_reg, res_col_reg;
  logic        cfg_err_reg, abort_reg, wait_seen_reg;

  logic        cfg_bad, beat, res_fire, timeout_hit;
  logic [3:0]  ld_row_max, ld_col_max;
  logic        ld_row_last, ld_col_last, res_row_last, res_col_last;

  assign cfg_bad = (a1 == 4'd0) || (a2 == 4'd0) || (a3 == 4'd0) ||
                   ({1'b0, a1} > MAX_DIM_W) || ({1'b0, a2} > MAX_DIM_W) ||
                   ({1'b0, a3} > MAX_DIM_W);

  assign in_ready  = (state_reg == LOAD_A) || (state_reg == LOAD_B);
  assign beat      = in_valid && in_ready;
  assign res_valid = (state_reg == READOUT);
  assign res_fire  = res_valid && res_ready;
  assign res_data  = acc_in;
  assign start_mm  = (state_reg == START);
  assign ack_ticks = (state_reg == ACK);
  assign done      = (state_reg == ACK) && !abort_reg;
  assign busy      = (state_reg != IDLE);
  assign cfg_err   = cfg_err_reg;
  assign row       = row_reg;
  assign col       = col_reg;
  assign Din       = din_reg;
  assign readA     = read_a_reg;
  assign readB     = read_b_reg;
  assign res_row   = res_row_reg;
  assign res_col   = res_col_reg;

  // A is walked as a1 x a2, B as a2 x a3; the shared load counters switch limits by state.
  always_comb begin
    ld_row_max = a1m_reg;
    ld_col_max = a2m_reg;
    if (state_reg == LOAD_B) begin
      ld_row_max = a2m_reg;
      ld_col_max = a3m_reg;
    end
  end

  assign ld_row_last  = (ld_row_reg == ld_row_max);
  assign ld_col_last  = (ld_col_reg == ld_col_max);
  assign res_row_last = (res_row_reg == a1m_reg);
  assign res_col_last = (res_col_reg == a3m_reg);

`ifdef MM_SEQUENCER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] wait_cnt_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_cnt_reg <= '0;
    end else if (state_reg == WAIT) begin
      wait_cnt_reg <= wait_cnt_reg + TW'(1);
    end else begin
      wait_cnt_reg <= '0;
    end
  end

  assign timeout_hit = (state_reg == WAIT) && !(wait_seen_reg && all_finished) &&
                       (wait_cnt_reg == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (cfg_valid && !cfg_bad) state_next = LOAD_A;
      LOAD_A:  if (beat && ld_row_last && ld_col_last) state_next = LOAD_B;
      LOAD_B:  if (beat && ld_row_last && ld_col_last) state_next = START;
      START:   state_next = WAIT;
      // wait_seen_reg masks all_finished for the first WAIT cycle (stale flags from the previous job)
      WAIT: begin
        if (timeout_hit) state_next = ACK;
        else if (wait_seen_reg && all_finished) state_next = READOUT;
      end
      READOUT: if (res_fire && res_row_last && res_col_last) state_next = ACK;
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      a1m_reg       <= '0;
      a2m_reg       <= '0;
      a3m_reg       <= '0;
      ld_row_reg    <= '0;
      ld_col_reg    <= '0;
      row_reg       <= '0;
      col_reg       <= '0;
      din_reg       <= '0;
      read_a_reg    <= 1'b0;
      read_b_reg    <= 1'b0;
      res_row_reg   <= '0;
      res_col_reg   <= '0;
      cfg_err_reg   <= 1'b0;
      abort_reg     <= 1'b0;
      wait_seen_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cfg_err_reg   <= 1'b0;
      read_a_reg    <= 1'b0;
      read_b_reg    <= 1'b0;
      wait_seen_reg <= (state_reg == WAIT);

      if (state_reg == IDLE && cfg_valid) begin
        if (cfg_bad) begin
          cfg_err_reg <= 1'b1;
        end else begin
          a1m_reg     <= a1 - 4'd1;
          a2m_reg     <= a2 - 4'd1;
          a3m_reg     <= a3 - 4'd1;
          ld_row_reg  <= '0;
          ld_col_reg  <= '0;
          res_row_reg <= '0;
          res_col_reg <= '0;
          abort_reg   <= 1'b0;
        end
      end

      if (beat) begin
        row_reg    <= ld_row_reg;
        col_reg    <= ld_col_reg;
        din_reg    <= in_data;
        read_a_reg <= (state_reg == LOAD_A);
        read_b_reg <= (state_reg == LOAD_B);
        if (ld_col_last) begin
          ld_col_reg <= '0;
          ld_row_reg <= ld_row_last ? 4'd0 : ld_row_reg + 4'd1;
        end else begin
          ld_col_reg <= ld_col_reg + 4'd1;
        end
      end

      if (res_fire) begin
        if (res_col_last) begin
          res_col_reg <= '0;
          res_row_reg <= res_row_last ? 4'd0 : res_row_reg + 4'd1;
        end else begin
          res_col_reg <= res_col_reg + 4'd1;
        end
      end

      if (timeout_hit) begin
        cfg_err_reg <= 1'b1;
        abort_reg   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mm_sequencer.sv
// Directed bench for mm_sequencer: load/start/readout flow, config errors, backpressure and reset.
`define CHK(tag, o, e) check(tag, 64'(o), 64'(e))

module tb_mm_sequencer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [3:0]  a1 = '0, a2 = '0, a3 = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic [3:0]  row, col;
  logic        readA, readB;
  logic [31:0] Din;
  logic        start_mm, ack_ticks;
  logic        all_finished = 1'b0;
  logic [3:0]  res_row, res_col;
  logic [31:0] acc_in = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        busy, done, cfg_err;

  int total = 0;
  int passed = 0;

  int c_exp[4]   = '{19, 22, 43, 50};
  int row3_exp[5] = '{0, 1, 2, 0, 0};
  int col3_exp[5] = '{0, 0, 0, 0, 1};

  mm_sequencer #(.MAX_DIM(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid),
    .a1(a1), .a2(a2), .a3(a3),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .row(row), .col(col), .readA(readA), .readB(readB), .Din(Din),
    .start_mm(start_mm), .ack_ticks(ack_ticks), .all_finished(all_finished),
    .res_row(res_row), .res_col(res_col), .acc_in(acc_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  function automatic logic [63:0] out_vec();
    return 64'({busy, in_ready, readA, readB, start_mm, ack_ticks, res_valid, done, cfg_err,
                row, col, res_row, res_col, Din});
  endfunction

  initial begin
    int beats;
    int last_row, last_col, last_din;
    logic exp_a;
    int kk;

    // reset state
    repeat (2) tick;
    `CHK("reset_outputs", out_vec(), 0);
    reset_n = 1'b1;

    // 2x2x2 job, in_valid held high
    tick;
    cfg_valid = 1'b1; a1 = 4'd2; a2 = 4'd2; a3 = 4'd2; in_valid = 1'b1; in_data = 32'd1;
    tick;
    `CHK("t1_in_ready", in_ready, 1);
    `CHK("t1_busy", busy, 1);
    a2 = 4'd0;  // cfg_valid stays high with a bad dimension while busy; must be ignored
    for (int b = 0; b < 8; b++) begin
      tick;
      exp_a = (b < 4);
      kk = (b < 4) ? b : b - 4;
      total++;
      if (readA === exp_a) passed++;
      else $error("FAIL t1_readA: observed %0h expected %0h", readA, exp_a);
      `CHK("t1_readB", readB, !exp_a);
      `CHK("t1_row", row, kk / 2);
      `CHK("t1_col", col, kk % 2);
      `CHK("t1_din", Din, b + 1);
      `CHK("t1_start_mm", start_mm, (b == 7));
      `CHK("t1_in_ready_load", in_ready, (b < 7));
      `CHK("t1_no_cfg_err", cfg_err, 0);
      in_data = 32'(b + 2);
    end
    cfg_valid = 1'b0; in_valid = 1'b0; a2 = 4'd2;
    for (int c = 0; c < 10; c++) begin
      tick;
      `CHK("t1_wait_res_valid", res_valid, 0);
      `CHK("t1_wait_busy", busy, 1);
      `CHK("t1_wait_start", start_mm, 0);
    end
    all_finished = 1'b1; res_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      tick;
      acc_in = 32'(c_exp[r]);
      #1;
      `CHK("t1_res_valid", res_valid, 1);
      `CHK("t1_res_row", res_row, r / 2);
      `CHK("t1_res_col", res_col, r % 2);
      total++;
      if (res_data === 32'(c_exp[r])) passed++;
      else $error("FAIL t1_res_data: observed %0h expected %0h", res_data, c_exp[r]);
      `CHK("t1_res_no_done", done, 0);
    end
    tick;
    `CHK("t1_done", done, 1);
    `CHK("t1_ack", ack_ticks, 1);
    all_finished = 1'b0; res_ready = 1'b0;
    tick;
    `CHK("t1_done_clear", done, 0);
    `CHK("t1_ack_clear", ack_ticks, 0);
    `CHK("t1_idle", busy, 0);

    // rejected configurations
    cfg_valid = 1'b1; a1 = 4'd2; a2 = 4'd0; a3 = 4'd2;
    tick;
    `CHK("t2_a2zero_err", cfg_err, 1);
    `CHK("t2_a2zero_busy", busy, 0);
    `CHK("t2_a2zero_ready", in_ready, 0);
    cfg_valid = 1'b0;
    tick;
    `CHK("t2_a2zero_err_once", cfg_err, 0);
    cfg_valid = 1'b1; a1 = 4'd9; a2 = 4'd2;
    tick;
    `CHK("t2_a1big_err", cfg_err, 1);
    `CHK("t2_a1big_busy", busy, 0);
    `CHK("t2_a1big_ready", in_ready, 0);
    cfg_valid = 1'b0;
    tick;
    `CHK("t2_a1big_err_once", cfg_err, 0);
    `CHK("t2_a1big_idle", busy, 0);

    // 3x1x2 job, toggling in_valid, all_finished already high
    all_finished = 1'b1;
    cfg_valid = 1'b1; a1 = 4'd3; a2 = 4'd1; a3 = 4'd2; in_data = 32'd100;
    tick;
    cfg_valid = 1'b0; in_valid = 1'b1;
    beats = 0; last_row = 0; last_col = 0; last_din = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (i % 2 == 0) begin
        `CHK("t3_readA", readA, (beats < 3));
        `CHK("t3_readB", readB, (beats >= 3));
        `CHK("t3_row", row, row3_exp[beats]);
        `CHK("t3_col", col, col3_exp[beats]);
        `CHK("t3_din", Din, 100 + beats);
        last_row = row3_exp[beats]; last_col = col3_exp[beats]; last_din = 100 + beats;
        beats++;
      end else begin
        `CHK("t3_no_strobe", {readA, readB}, 0);
        `CHK("t3_hold", {row, col, Din}, {4'(last_row), 4'(last_col), 32'(last_din)});
      end
      `CHK("t3_start_mm", start_mm, (i == 8));
      if (i == 9) `CHK("t3_wait1_res_valid", res_valid, 0);
      in_valid = (i % 2 == 1) && (i < 9);
      if (in_valid) in_data = 32'(100 + beats);
    end
    tick;
    `CHK("t3_wait2_res_valid", res_valid, 0);
    `CHK("t3_wait2_busy", busy, 1);
    tick;
    `CHK("t3_readout_valid", res_valid, 1);
    `CHK("t3_readout_first", {res_row, res_col}, 8'h00);
    res_ready = 1'b1;
    tick;
    `CHK("t3_readout_second", {res_row, res_col}, 8'h01);
    res_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      tick;
      `CHK("t3_stall_index", {res_row, res_col}, 8'h01);
      `CHK("t3_stall_valid", res_valid, 1);
    end
    reset_n = 1'b0;
    tick;
    `CHK("t3_abort_outputs", out_vec(), 0);
    reset_n = 1'b1; all_finished = 1'b0;

`ifdef MM_SEQUENCER_TIMEOUT_EN
    // watchdog: 1x1x1 job whose threads never finish
    tick;
    cfg_valid = 1'b1; a1 = 4'd1; a2 = 4'd1; a3 = 4'd1; in_valid = 1'b1; in_data = 32'd7;
    tick;
    cfg_valid = 1'b0;
    tick;
    `CHK("t4_readA", readA, 1);
    tick;
    `CHK("t4_start", start_mm, 1);
    in_valid = 1'b0;
    for (int w = 0; w < 16; w++) begin
      tick;
      `CHK("t4_wait", {busy, ack_ticks, cfg_err, res_valid}, 4'b1000);
    end
    tick;
    `CHK("t4_timeout_err", cfg_err, 1);
    `CHK("t4_timeout_ack", ack_ticks, 1);
    `CHK("t4_timeout_no_done", done, 0);
    tick;
    `CHK("t4_idle", {busy, cfg_err, ack_ticks, done}, 4'b0000);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
